// File: rtl/uart_response_arbiter.sv
// rtl/uart_response_arbiter.sv - round-robin arbiter sharing the UART TX byte stream between ASC and STL responses
module uart_response_arbiter #(
  parameter int         MAX_BURST = 64,
  parameter int         IDLE_GAP  = 1024,
  parameter logic [7:0] ASC_TAG   = 8'h41,
  parameter logic [7:0] STL_TAG   = 8'h53
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       asc_valid,
  output logic       asc_ready,
  input  logic [7:0] asc_data,
  input  logic       stl_valid,
  output logic       stl_ready,
  input  logic [7:0] stl_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_GAP + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_STREAM} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;           // 0 = ASC, 1 = STL
  logic          last_grant, last_grant_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic          src_valid;
  logic [7:0]    src_data;

  assign src_valid = owner ? stl_valid : asc_valid;
  assign src_data  = owner ? stl_data  : asc_data;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_nxt;
      idle_cnt   <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    burst_nxt      = burst_cnt;
    idle_nxt       = idle_cnt;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    asc_ready      = 1'b0;
    stl_ready      = 1'b0;
    grant          = 2'b00;
    case (state)
      S_IDLE: begin
        if (asc_valid || stl_valid) begin
          // On a tie the source that did not own the previous grant wins.
          owner_nxt = (asc_valid && stl_valid) ? ~last_grant : stl_valid;
          state_nxt = S_TAG;
        end
      end
      S_TAG: begin
        grant    = owner ? 2'b10 : 2'b01;
        tx_valid = 1'b1;
        tx_data  = owner ? STL_TAG : ASC_TAG;
        if (tx_ready) begin
          state_nxt = S_STREAM;
          burst_nxt = '0;
          idle_nxt  = '0;
        end
      end
      S_STREAM: begin
        grant     = owner ? 2'b10 : 2'b01;
        tx_valid  = src_valid;
        tx_data   = src_data;
        asc_ready = ~owner & tx_ready;
        stl_ready = owner & tx_ready;
        if (src_valid && tx_ready) begin
          idle_nxt  = '0;
          burst_nxt = burst_cnt + BW'(1);
          if (burst_cnt == BURST_LAST) begin
            state_nxt      = S_IDLE;
            last_grant_nxt = owner;
          end
        end else if (src_valid) begin
          // A stalled sink must never look like an idle source.
          idle_nxt = '0;
        end else begin
          idle_nxt = idle_cnt + IW'(1);
          if (idle_cnt == IDLE_LAST) begin
            state_nxt      = S_IDLE;
            last_grant_nxt = owner;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_response_arbiter.sv
// tb/tb_uart_response_arbiter.sv - self-checking bench for uart_response_arbiter
module tb_uart_response_arbiter;

  localparam int         MAX_BURST = 4;
  localparam int         IDLE_GAP  = 8;
  localparam logic [7:0] A_TAG     = 8'h41;
  localparam logic [7:0] S_TAG     = 8'h53;

  logic       clk = 1'b0;
  logic       reset;
  logic       asc_valid, asc_ready, stl_valid, stl_ready;
  logic [7:0] asc_data, stl_data, tx_data;
  logic       tx_valid, tx_ready, busy;
  logic [1:0] grant;

  always #5 clk = ~clk;

  uart_response_arbiter #(
    .MAX_BURST(MAX_BURST), .IDLE_GAP(IDLE_GAP), .ASC_TAG(A_TAG), .STL_TAG(S_TAG)
  ) dut (
    .clk(clk), .reset(reset),
    .asc_valid(asc_valid), .asc_ready(asc_ready), .asc_data(asc_data),
    .stl_valid(stl_valid), .stl_ready(stl_ready), .stl_data(stl_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .grant(grant), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Output vector: {tx_valid, tx_data[7:0], asc_ready, stl_ready, grant[1:0], busy}
  function automatic logic [13:0] ov(logic tv, logic [7:0] td, logic ar, logic sr,
                                     logic [1:0] g, logic b);
    return {tv, td, ar, sr, g, b};
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {tx_valid, tx_data, asc_ready, stl_ready, grant, busy};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {tv,td,ar,sr,g,b}=%h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic sv,
                       input logic [7:0] sd, input logic tr);
    asc_valid = av; asc_data = ad; stl_valid = sv; stl_data = sd; tx_ready = tr;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic step_chk(input string name, input logic [13:0] exp);
    @(negedge clk); check(name, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic       av; logic [7:0] ad; logic sv; logic [7:0] sd; logic tr;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [7:0] ad, logic sv, logic [7:0] sd,
                              logic tr, logic [13:0] exp);
    vec_t v;
    v.av = av; v.ad = ad; v.sv = sv; v.sd = sd; v.tr = tr; v.exp = exp;
    return v;
  endfunction

  // Reference model: who owns the bus, whether its tag is still owed,
  // and how many bytes / quiet cycles it has had.
  int m_owner, m_sent, m_quiet, m_last;
  bit m_tag;

  function automatic logic [13:0] model_out();
    logic [1:0] g;
    logic       sv;
    logic [7:0] sd;
    if (m_owner < 0) return '0;
    g = (m_owner == 1) ? 2'b10 : 2'b01;
    if (m_tag) return ov(1'b1, (m_owner == 1) ? S_TAG : A_TAG, 1'b0, 1'b0, g, 1'b1);
    sv = (m_owner == 1) ? stl_valid : asc_valid;
    sd = (m_owner == 1) ? stl_data : asc_data;
    return ov(sv, sd, (m_owner == 0) && tx_ready, (m_owner == 1) && tx_ready, g, 1'b1);
  endfunction

  task automatic model_step();
    logic sv;
    if (m_owner < 0) begin
      if (asc_valid || stl_valid) begin
        m_owner = (asc_valid && stl_valid) ? 1 - m_last : (stl_valid ? 1 : 0);
        m_tag   = 1'b1;
      end
    end else if (m_tag) begin
      if (tx_ready) begin m_tag = 1'b0; m_sent = 0; m_quiet = 0; end
    end else begin
      sv = (m_owner == 1) ? stl_valid : asc_valid;
      if (sv && tx_ready) begin
        m_sent++; m_quiet = 0;
        if (m_sent == MAX_BURST) begin m_last = m_owner; m_owner = -1; end
      end else if (sv) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == IDLE_GAP) begin m_last = m_owner; m_owner = -1; end
      end
    end
  endtask

  initial begin
    logic [7:0]  got[$];
    logic [7:0]  want[$];
    logic [14:0] idle_mask;
    logic [7:0]  a_next, s_next;
    logic [13:0] e;
    bit          hold_a, hold_s;
    int          pa, ps;

    // Asynchronous reset with no clock edge yet
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00, 0);
    #1 check("reset_no_edge", '0);

    // ASC sends 11,22,33 then goes idle; then an STL grant under a stalled tag
    vecs.push_back(mk(1, 8'h11, 0, 8'h00, 1, ov(0, 8'h00, 0, 0, 2'b00, 0)));
    vecs.push_back(mk(1, 8'h11, 0, 8'h00, 1, ov(1, A_TAG, 0, 0, 2'b01, 1)));
    vecs.push_back(mk(1, 8'h11, 0, 8'h00, 1, ov(1, 8'h11, 1, 0, 2'b01, 1)));
    vecs.push_back(mk(1, 8'h22, 0, 8'h00, 1, ov(1, 8'h22, 1, 0, 2'b01, 1)));
    vecs.push_back(mk(1, 8'h33, 0, 8'h00, 1, ov(1, 8'h33, 1, 0, 2'b01, 1)));
    for (int i = 0; i < IDLE_GAP; i++)
      vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, ov(0, 8'h00, 1, 0, 2'b01, 1)));
    vecs.push_back(mk(0, 8'h00, 0, 8'h00, 1, ov(0, 8'h00, 0, 0, 2'b00, 0)));
    vecs.push_back(mk(0, 8'h00, 1, 8'h5a, 0, ov(0, 8'h00, 0, 0, 2'b00, 0)));
    vecs.push_back(mk(0, 8'h00, 1, 8'h5a, 0, ov(1, S_TAG, 0, 0, 2'b10, 1)));
    vecs.push_back(mk(0, 8'h00, 1, 8'h5a, 1, ov(1, S_TAG, 0, 0, 2'b10, 1)));
    vecs.push_back(mk(1, 8'h77, 1, 8'h5a, 1, ov(1, 8'h5a, 0, 1, 2'b10, 1)));
    vecs.push_back(mk(1, 8'h77, 0, 8'h00, 1, ov(0, 8'h00, 0, 1, 2'b10, 1)));

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ad, vecs[i].sv, vecs[i].sd, vecs[i].tr);
      step_chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Both sources always valid: alternating tagged bursts, one IDLE cycle apart
    do_reset();
    a_next = 8'ha0; s_next = 8'hb0; idle_mask = '0;
    for (int c = 0; c < 15; c++) begin
      drive(1, a_next, 1, s_next, 1);
      @(negedge clk);
      if (!busy) idle_mask[c] = 1'b1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (asc_ready) a_next++;
      if (stl_ready) s_next++;
      @(posedge clk); #1;
    end
    want = '{8'h41, 8'ha0, 8'ha1, 8'ha2, 8'ha3, 8'h53, 8'hb0, 8'hb1, 8'hb2, 8'hb3,
             8'h41, 8'ha4};
    n_tests++;
    if (got.size() != want.size()) begin
      n_fail++;
      $display("FAIL rr_count: got %0d bytes required %0d", got.size(), want.size());
    end
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== want[i]) begin
        n_fail++;
        $display("FAIL rr_byte%0d: got %h required %h", i, got[i], want[i]);
      end
    end
    n_tests++;
    if (idle_mask !== 15'h1041) begin
      n_fail++;
      $display("FAIL rr_idle_cycles: got %h required %h", idle_mask, 15'h1041);
    end

    // Backpressure longer than IDLE_GAP keeps the grant and the byte
    do_reset();
    drive(1, 8'h11, 0, 8'h00, 1);
    step(); step();
    step_chk("bp_first", ov(1, 8'h11, 1, 0, 2'b01, 1));
    drive(1, 8'h22, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) step_chk($sformatf("bp_hold%0d", i), ov(1, 8'h22, 0, 0, 2'b01, 1));
    drive(1, 8'h22, 0, 8'h00, 1);
    step_chk("bp_release", ov(1, 8'h22, 1, 0, 2'b01, 1));
    drive(1, 8'h33, 0, 8'h00, 1);
    step_chk("bp_next", ov(1, 8'h33, 1, 0, 2'b01, 1));

    // Idle gap: IDLE_GAP-1 quiet cycles keep the grant, IDLE_GAP drops it
    do_reset();
    drive(1, 8'h11, 0, 8'h00, 1);
    step(); step();
    step_chk("gap_first", ov(1, 8'h11, 1, 0, 2'b01, 1));
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (IDLE_GAP - 1) step();
    drive(1, 8'h22, 0, 8'h00, 1);
    step_chk("gap_short", ov(1, 8'h22, 1, 0, 2'b01, 1));
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (IDLE_GAP) step();
    drive(1, 8'h33, 0, 8'h00, 1);
    step_chk("gap_idle", ov(0, 8'h00, 0, 0, 2'b00, 0));
    step_chk("gap_retag", ov(1, A_TAG, 0, 0, 2'b01, 1));
    step_chk("gap_byte", ov(1, 8'h33, 1, 0, 2'b01, 1));

    // Reset mid-STREAM: outputs clear at once; afterwards ASC wins the tie
    do_reset();
    drive(1, 8'h11, 0, 8'h00, 1);
    step(); step();
    step_chk("rst_stream", ov(1, 8'h11, 1, 0, 2'b01, 1));
    drive(1, 8'h22, 0, 8'h00, 1);
    #1 reset = 1'b1;
    #1 check("rst_async", '0);
    @(posedge clk); #1 reset = 1'b0;
    drive(1, 8'h55, 1, 8'h66, 1);
    step_chk("rst_after_idle", ov(0, 8'h00, 0, 0, 2'b00, 0));
    step_chk("rst_after_tag", ov(1, A_TAG, 0, 0, 2'b01, 1));

    // Randomized traffic against the reference model
    do_reset();
    m_owner = -1; m_tag = 1'b0; m_sent = 0; m_quiet = 0; m_last = 1;
    hold_a = 1'b0; hold_s = 1'b0; pa = 50; ps = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        pa = (($urandom % 3) == 0) ? 3 : (($urandom % 2) == 0) ? 40 : 95;
        ps = (($urandom % 3) == 0) ? 3 : (($urandom % 2) == 0) ? 40 : 95;
      end
      if (!hold_a) begin
        asc_valid = ($urandom_range(0, 99) < pa);
        asc_data  = 8'($urandom);
      end
      if (!hold_s) begin
        stl_valid = ($urandom_range(0, 99) < ps);
        stl_data  = 8'($urandom);
      end
      tx_ready = ($urandom_range(0, 99) < 70);
      e = model_out();
      @(negedge clk);
      check($sformatf("rand%0d", c), e);
      hold_a = asc_valid && !e[4];
      hold_s = stl_valid && !e[3];
      model_step();
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
